// File: rtl/bus_arbiter_ctrl.sv
// Two-master bus arbiter: grants the bus, latches the owner's slave select, enforces a BUSY timeout.
// Define ARB_FIXED_PRIORITY_EN for fixed priority (master 1 wins ties); default is round-robin.
module bus_arbiter_ctrl #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       m1_req,
  input  logic       m2_req,
  input  logic [1:0] m1_sel,
  input  logic [1:0] m2_sel,
  input  logic       bus_done,
  output logic       m1_grant,
  output logic       m2_grant,
  output logic [1:0] slv_sel,
  output logic       slv_en,
  output logic       arb_busy,
  output logic       sel_err,
  output logic       timeout_err
);

  typedef enum logic [1:0] {IDLE, GRANT, BUSY, RELEASE} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             m1_grant_n, m2_grant_n, slv_en_n, arb_busy_n, sel_err_n, timeout_err_n;
  logic [1:0]       slv_sel_n;
  logic             owner_req, pick_m2;

`ifndef ARB_FIXED_PRIORITY_EN
  // 1 = master 2 owned the bus last; reset to 1 so master 1 wins the first tie.
  logic last_owner, last_owner_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) last_owner <= 1'b1;
    else     last_owner <= last_owner_n;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      m1_grant    <= 1'b0;
      m2_grant    <= 1'b0;
      slv_sel     <= 2'b00;
      slv_en      <= 1'b0;
      arb_busy    <= 1'b0;
      sel_err     <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      m1_grant    <= m1_grant_n;
      m2_grant    <= m2_grant_n;
      slv_sel     <= slv_sel_n;
      slv_en      <= slv_en_n;
      arb_busy    <= arb_busy_n;
      sel_err     <= sel_err_n;
      timeout_err <= timeout_err_n;
    end
  end

  always_comb begin
    state_n       = state;
    cnt_n         = cnt;
    m1_grant_n    = m1_grant;
    m2_grant_n    = m2_grant;
    slv_sel_n     = slv_sel;
    slv_en_n      = slv_en;
    arb_busy_n    = arb_busy;
    sel_err_n     = 1'b0;
    timeout_err_n = 1'b0;
`ifndef ARB_FIXED_PRIORITY_EN
    last_owner_n  = last_owner;
    pick_m2       = !m1_req || (m2_req && !last_owner);
`else
    pick_m2       = !m1_req;
`endif
    owner_req     = m1_grant ? m1_req : m2_req;

    case (state)
      IDLE: begin
        if (m1_req || m2_req) begin
          m1_grant_n = !pick_m2;
          m2_grant_n = pick_m2;
          slv_sel_n  = pick_m2 ? m2_sel : m1_sel;
          arb_busy_n = 1'b1;
`ifndef ARB_FIXED_PRIORITY_EN
          last_owner_n = pick_m2;
`endif
          state_n    = GRANT;
        end
      end
      GRANT: begin
        if (slv_sel == 2'b11) begin
          sel_err_n  = 1'b1;
          m1_grant_n = 1'b0;
          m2_grant_n = 1'b0;
          arb_busy_n = 1'b0;
          slv_sel_n  = 2'b00;
          state_n    = RELEASE;
        end else begin
          slv_en_n = 1'b1;
          cnt_n    = '0;
          state_n  = BUSY;
        end
      end
      BUSY: begin
        cnt_n = cnt + CNT_W'(1);
        // Done beats abort beats timeout; a timeout is only flagged when neither other exit applies.
        if (bus_done || !owner_req || cnt == CNT_LAST) begin
          timeout_err_n = !bus_done && owner_req;
          m1_grant_n    = 1'b0;
          m2_grant_n    = 1'b0;
          slv_en_n      = 1'b0;
          arb_busy_n    = 1'b0;
          slv_sel_n     = 2'b00;
          cnt_n         = '0;
          state_n       = RELEASE;
        end
      end
      RELEASE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_bus_arbiter_ctrl.sv
// Self-checking bench for bus_arbiter_ctrl: directed scenarios plus random traffic against a phase-level model.
module tb_bus_arbiter_ctrl;
  localparam int TO = 16;

  logic       clk, rst;
  logic       m1_req, m2_req, bus_done;
  logic [1:0] m1_sel, m2_sel;
  logic       m1_grant, m2_grant, slv_en, arb_busy, sel_err, timeout_err;
  logic [1:0] slv_sel;

  int checks = 0;
  int errors = 0;

  bus_arbiter_ctrl #(.TIMEOUT_CYCLES(TO), .CNT_W(5)) dut (
    .clk(clk), .rst(rst),
    .m1_req(m1_req), .m2_req(m2_req),
    .m1_sel(m1_sel), .m2_sel(m2_sel),
    .bus_done(bus_done),
    .m1_grant(m1_grant), .m2_grant(m2_grant),
    .slv_sel(slv_sel), .slv_en(slv_en), .arb_busy(arb_busy),
    .sel_err(sel_err), .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: phase 0 idle, 1 granted, 2 transferring, 3 turnaround; own/last are master numbers.
  int   ph, own, last, lsel, el;
  logic e_serr, e_terr;

  task automatic model_reset();
    ph = 0; own = 0; last = 2; lsel = 0; el = 0; e_serr = 1'b0; e_terr = 1'b0;
  endtask

  task automatic model_step();
    int oreq;
    e_serr = 1'b0;
    e_terr = 1'b0;
    case (ph)
      0: if (m1_req || m2_req) begin
        if (m1_req && m2_req) begin
`ifdef ARB_FIXED_PRIORITY_EN
          own = 1;
`else
          own = (last == 1) ? 2 : 1;
`endif
        end else own = m1_req ? 1 : 2;
        last = own;
        lsel = (own == 1) ? int'(m1_sel) : int'(m2_sel);
        ph   = 1;
      end
      1: if (lsel == 3) begin e_serr = 1'b1; ph = 3; end
         else begin ph = 2; el = 0; end
      2: begin
        el++;
        oreq = (own == 1) ? int'(m1_req) : int'(m2_req);
        if (bus_done || oreq == 0) ph = 3;
        else if (el == TO) begin e_terr = 1'b1; ph = 3; end
      end
      default: ph = 0;
    endcase
  endtask

  function automatic logic [7:0] exp_vec();
    logic       held;
    logic [1:0] s;
    held = (ph == 1 || ph == 2);
    s    = held ? 2'(lsel) : 2'b00;
    return {held && own == 1, held && own == 2, s, ph == 2, held, e_serr, e_terr};
  endfunction

  function automatic logic [7:0] dut_vec();
    return {m1_grant, m2_grant, slv_sel, slv_en, arb_busy, sel_err, timeout_err};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: model advances on the edge, outputs compared on the following falling edge.
  task automatic step();
    @(posedge clk);
    if (rst) model_reset(); else model_step();
    @(negedge clk);
    chk("outputs", 32'(dut_vec()), 32'(exp_vec()));
    chk("grant_excl", 32'(m1_grant & m2_grant), 32'd0);
    chk("en_sel_valid", 32'(slv_en && slv_sel == 2'b11), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    int n, gap, prev, cur, serr_cnt, en_cnt;
    int gq[$];

    rst = 1'b1; m1_req = 0; m2_req = 0; m1_sel = 0; m2_sel = 0; bus_done = 0;
    model_reset();
    @(negedge clk);
    chk("reset_state", 32'(dut_vec()), 32'd0);
    rst = 1'b0;

    // Single master
    m1_req = 1; m1_sel = 2'b01;
    step(); chk("sm_grant", 32'(m1_grant), 32'd1);
    step(); chk("sm_en", 32'({slv_en, slv_sel}), 32'b101);
    step(); step();
    bus_done = 1; step(); bus_done = 0;
    chk("sm_release", 32'({m1_grant, arb_busy, slv_sel}), 32'd0);
    m1_req = 0;
    step(); chk("sm_idle", 32'(arb_busy), 32'd0);

    // Contention with done after every grant
    do_reset();
    m1_req = 1; m2_req = 1; m1_sel = 2'b00; m2_sel = 2'b10;
    prev = 0; gap = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      bus_done = slv_en;
      cur = m1_grant ? 1 : (m2_grant ? 2 : 0);
      if (cur != 0 && prev == 0) begin
        if (gq.size() > 0) chk("contend_gap", 32'(gap >= 1), 32'd1);
        gq.push_back(cur);
        gap = 0;
      end
      if (cur == 0) gap++;
      prev = cur;
    end
    bus_done = 0; m1_req = 0; m2_req = 0;
    chk("contend_count", 32'(gq.size() >= 4), 32'd1);
    for (int i = 0; i < 4 && i < gq.size(); i++) begin
`ifdef ARB_FIXED_PRIORITY_EN
      chk("contend_order", 32'(gq[i]), 32'd1);
`else
      chk("contend_order", 32'(gq[i]), (i % 2 == 0) ? 32'd1 : 32'd2);
`endif
    end
    step(); step();

    // Invalid select
    m2_req = 1; m2_sel = 2'b11;
    step(); chk("inv_grant", 32'(m2_grant), 32'd1);
    m2_req = 0;
    serr_cnt = 0; en_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      serr_cnt += int'(sel_err);
      en_cnt   += int'(slv_en);
    end
    chk("inv_serr_count", 32'(serr_cnt), 32'd1);
    chk("inv_en_never", 32'(en_cnt), 32'd0);

    // Timeout: count cycles from BUSY entry to timeout_err
    m1_req = 1; m1_sel = 2'b10;
    step(); step();
    chk("to_in_busy", 32'(slv_en), 32'd1);
    n = 0;
    while (!timeout_err && n < 40) begin step(); n++; end
    chk("to_latency", 32'(n), 32'd16);
    chk("to_grant_drop", 32'(m1_grant), 32'd0);
    // Done on the last counted cycle suppresses the timeout
    n = 0;
    while (!slv_en && n < 10) begin step(); n++; end
    chk("to2_in_busy", 32'(slv_en), 32'd1);
    for (int i = 0; i < 15; i++) step();
    bus_done = 1; step(); bus_done = 0;
    chk("to_done_wins", 32'({timeout_err, m1_grant}), 32'd0);
    m1_req = 0; step(); step();

    // Abort
    m1_req = 1; m1_sel = 2'b00;
    step(); step(); step();
    m1_req = 0;
    step(); chk("abort_release", 32'({m1_grant, slv_en, arb_busy}), 32'd0);
    step();

    // Asynchronous reset mid-BUSY
    m1_req = 1; m1_sel = 2'b01;
    step(); step(); step();
    rst = 1'b1;
    #1;
    chk("async_reset", 32'(dut_vec()), 32'd0);
    model_reset();
    m2_req = 1;
    @(negedge clk);
    rst = 1'b0;
    step(); chk("post_reset_m1_first", 32'({m1_grant, m2_grant}), 32'b10);
    m1_req = 0; m2_req = 0;
    step(); step(); step();

    // Random traffic
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(7) == 0) m1_req = ~m1_req;
      if ($urandom_range(7) == 0) m2_req = ~m2_req;
      m1_sel   = 2'($urandom_range(3));
      m2_sel   = 2'($urandom_range(3));
      bus_done = ($urandom_range(9) == 0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
